lsu_mem_access: RTL and testbench
=================================

Name: lsu_mem_access

Overview:
- Memory access stage directly downstream of the memory-control decoder.
- Consumes the decoded mem_ctrl_t command together with the effective address, store data and the load-unsigned flag.
- Performs byte-lane alignment, write-strobe generation and misalignment checking, and runs a single-outstanding request/response transaction on the data bus.
- Returns a sign- or zero-extended load result, or a store completion, to the writeback side.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed in WAIT_RSP before aborting with an error; 0 disables the timeout.

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  command valid; sampled only in IDLE
mem_ctrl  in  mem_ctrl_t  decoded command: NONE / READ_BYTE/HALF/WORD / STORE_BYTE/HALF/WORD
addr  in  32  effective byte address
wdata  in  32  store data; low byte/half/word significant
load_unsigned  in  1  1 = zero-extend loads (funct3[2]); ignored for stores and word loads
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done: misaligned access or bus timeout
rdata  out  32  extended load result, valid with done; held until the next done
bus_req_valid  out  1  request valid
bus_req_ready  in  1  request accepted
bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}
bus_we  out  1  1 = write
bus_wstrb  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_rsp_valid  in  1  response valid; sampled only in WAIT_RSP
bus_rdata  in  32  read data, full word

Behaviour:
- Reset (async, immediate): state IDLE, all outputs 0, timeout counter 0. Reset in any state abandons the transaction; no done pulse is produced.
- Command accept: start=1 in IDLE with mem_ctrl != NONE. The command is accepted that cycle and addr, lane, size, we, extension mode and wdata are registered. start while busy, or with NONE, is ignored (no done).
- Misalignment check: HALF with addr[0]=1, or WORD with addr[1:0] != 0 -> FAULT (no bus request). FAULT lasts one cycle, then done=1, err=1, rdata unchanged, return to IDLE.
- REQ state:
  - bus_req_valid=1; bus_addr/we/wstrb/wdata stable until bus_req_ready=1.
  - On a ready cycle go to WAIT_RSP; bus_req_valid drops the next cycle.
  - No timeout in REQ.
- Strobes:
  - Byte: wstrb = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - Half: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 4'b1111, wdata unchanged.
  - Reads: wstrb = 0, we = 0.
- WAIT_RSP state:
  - Counter increments each cycle.
  - On bus_rsp_valid: loads select lane bus_rdata[8*addr[1:0] +: 8] or bus_rdata[16*addr[1] +: 16], extend per load_unsigned, register into rdata. Stores ignore bus_rdata.
  - Go to DONE.
  - If the counter reaches TIMEOUT_CYCLES with no response -> DONE with err=1. A response in that same cycle wins (err=0).
- DONE state: done=1 for exactly one cycle, then IDLE. A start in DONE is ignored; the earliest next accept is the following cycle.
- Latency: with ready and response each arriving on their first eligible cycle, accept in cycle 0, REQ in cycle 1, WAIT_RSP in cycle 2 (response), done in cycle 3.
- bus_rsp_valid outside WAIT_RSP is ignored. Only one transaction is outstanding at a time.

Decomposition:
- Shared types package: lsu_state_t (IDLE, REQ, WAIT_RSP, DONE, FAULT), mem_size_t (BYTE, HALF, WORD), strb_t (logic[3:0]).
- Reuse existing word_t and mem_ctrl_t.
- One combinational sub-module, lsu_lane_align: store strobe/replication and load lane extraction/extension. The FSM and timeout counter stay in the top level.

Test Plan:
- STORE_BYTE, addr=0x1003, wdata=0x000000A5, ready immediate -> bus_addr=0x1000, wstrb=4'b1000, bus_wdata=0xA5A5A5A5, we=1; done at cycle 3, err=0.
- READ_HALF signed, addr=0x2002, bus_rdata=0x8001_1234 -> rdata=0xFFFF8001. Same access with load_unsigned=1 -> rdata=0x00008001.
- READ_WORD, addr=0x3001 -> no bus_req_valid ever; done and err on cycle 2; rdata keeps its previous value.
- READ_BYTE, addr=0x4001, bus_req_ready low for 3 cycles -> bus_req_valid/addr held stable throughout; after the response bus_rdata=0x0000_7F00, rdata=0x0000007F.
- TIMEOUT_CYCLES=4, no response -> done and err after 4 WAIT_RSP cycles. Repeat with the response arriving on the 4th cycle -> err=0.
- Assert rst mid-WAIT_RSP, then a start pulse in the DONE cycle -> all outputs 0 immediately and no done pulse; the start in DONE is ignored.

Source files
------------

// File: rtl/lsu_mem_access_pkg.sv
// Shared types for the load/store memory access stage: command encoding,
// access sizes, FSM states and small decode helpers.
package lsu_mem_access_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strb_t;

  typedef enum logic [2:0] {
    NONE,
    READ_BYTE,
    READ_HALF,
    READ_WORD,
    STORE_BYTE,
    STORE_HALF,
    STORE_WORD
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE,
    FAULT
  } lsu_state_t;

  function automatic mem_size_t ctrl_size(input mem_ctrl_t ctrl);
    case (ctrl)
      READ_HALF, STORE_HALF: return HALF;
      READ_WORD, STORE_WORD: return WORD;
      default:               return BYTE;
    endcase
  endfunction

  function automatic logic ctrl_is_store(input mem_ctrl_t ctrl);
    return (ctrl == STORE_BYTE) || (ctrl == STORE_HALF) || (ctrl == STORE_WORD);
  endfunction

  // Halves need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lane);
    case (size)
      HALF:    return lane[0];
      WORD:    return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobes and data replication towards the bus,
// load lane extraction and sign/zero extension from the bus.
module lsu_lane_align
  import lsu_mem_access_pkg::*;
(
  input  mem_size_t   size,
  input  logic        we,
  input  logic [1:0]  lane,
  input  logic        load_unsigned,
  input  word_t       store_data,
  input  word_t       bus_rdata,
  output strb_t       wstrb,
  output word_t       wdata_rep,
  output word_t       load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wstrb     = '0;
    wdata_rep = store_data;
    case (size)
      BYTE: begin
        wstrb     = strb_t'(4'b0001 << lane);
        wdata_rep = {4{store_data[7:0]}};
      end
      HALF: begin
        wstrb     = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{store_data[15:0]}};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_rep = store_data;
      end
    endcase
    if (!we) begin
      wstrb = '0;
    end
  end

  // Loads: pick the addressed lane, then extend unless the access is a word.
  always_comb begin
    byte_sel  = bus_rdata[{lane, 3'b000} +: 8];
    half_sel  = bus_rdata[{lane[1], 4'b0000} +: 16];
    load_data = bus_rdata;
    case (size)
      BYTE:    load_data = {{24{byte_sel[7] & ~load_unsigned}}, byte_sel};
      HALF:    load_data = {{16{half_sel[15] & ~load_unsigned}}, half_sel};
      default: load_data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Memory access stage: accepts a decoded load/store, checks alignment and runs
// one request/response transaction on the data bus with an optional timeout.
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  mem_ctrl_t  mem_ctrl,
  input  word_t      addr,
  input  word_t      wdata,
  input  logic       load_unsigned,
  output logic       busy,
  output logic       done,
  output logic       err,
  output word_t      rdata,
  output logic       bus_req_valid,
  input  logic       bus_req_ready,
  output word_t      bus_addr,
  output logic       bus_we,
  output strb_t      bus_wstrb,
  output word_t      bus_wdata,
  input  logic       bus_rsp_valid,
  input  word_t      bus_rdata
);

  lsu_state_t state, state_n;

  word_t      addr_q;
  word_t      wdata_q;
  mem_size_t  size_q;
  logic       we_q;
  logic       unsigned_q;
  logic       err_q;
  logic [31:0] wait_cnt;

  logic       accept;
  logic       cmd_misaligned;
  logic       timeout_hit;
  word_t      load_data;

  assign accept         = (state == IDLE) && start && (mem_ctrl != NONE);
  assign cmd_misaligned = is_misaligned(ctrl_size(mem_ctrl), addr[1:0]);
  // The cycle in which the counter reaches the limit is the last one a response may arrive.
  assign timeout_hit    = (TIMEOUT_CYCLES != 0) && (wait_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (accept) state_n = cmd_misaligned ? FAULT : REQ;
      REQ:      if (bus_req_ready) state_n = WAIT_RSP;
      WAIT_RSP: if (bus_rsp_valid || timeout_hit) state_n = DONE;
      FAULT:    state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= BYTE;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
      rdata      <= '0;
    end else begin
      if (accept) begin
        addr_q     <= addr;
        wdata_q    <= wdata;
        size_q     <= ctrl_size(mem_ctrl);
        we_q       <= ctrl_is_store(mem_ctrl);
        unsigned_q <= load_unsigned;
        err_q      <= cmd_misaligned;
      end
      if (state == REQ && bus_req_ready) begin
        wait_cnt <= '0;
      end else if (state == WAIT_RSP) begin
        wait_cnt <= wait_cnt + 32'd1;
      end
      if (state == WAIT_RSP) begin
        if (bus_rsp_valid) begin
          if (!we_q) begin
            rdata <= load_data;
          end
        end else if (timeout_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  lsu_lane_align u_align (
    .size          (size_q),
    .we            (we_q),
    .lane          (addr_q[1:0]),
    .load_unsigned (unsigned_q),
    .store_data    (wdata_q),
    .bus_rdata     (bus_rdata),
    .wstrb         (bus_wstrb),
    .wdata_rep     (bus_wdata),
    .load_data     (load_data)
  );

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign err           = (state == DONE) && err_q;
  assign bus_req_valid = (state == REQ);
  assign bus_addr      = {addr_q[31:2], 2'b00};
  assign bus_we        = we_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: a schedule-based transaction model drives
// the bus and predicts done/err/rdata and request contents every cycle.
module tb_lsu_mem_access;
  import lsu_mem_access_pkg::*;

  localparam int TIMEOUT = 4;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      start = 1'b0;
  mem_ctrl_t mem_ctrl = NONE;
  word_t     addr = '0;
  word_t     wdata = '0;
  logic      load_unsigned = 1'b0;
  logic      busy, done, err;
  word_t     rdata;
  logic      bus_req_valid;
  logic      bus_req_ready = 1'b0;
  word_t     bus_addr;
  logic      bus_we;
  strb_t     bus_wstrb;
  word_t     bus_wdata;
  logic      bus_rsp_valid = 1'b0;
  word_t     bus_rdata = '0;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Model state shared between the stimulus tasks and the compare process.
  logic  txn_open = 1'b0;
  logic  exp_req_valid = 1'b0;
  logic  exp_done_now = 1'b0;
  logic  exp_err = 1'b0;
  word_t exp_rdata_next = '0;
  word_t model_rdata = '0;
  word_t exp_bus_addr = '0;
  logic  exp_bus_we = 1'b0;
  strb_t exp_bus_wstrb = '0;
  word_t exp_bus_wdata = '0;

  logic  cap_seen;
  word_t cap_addr;
  logic  cap_we;
  strb_t cap_wstrb;
  word_t cap_wdata;
  int    done_at;

  lsu_mem_access #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_ctrl      (mem_ctrl),
    .addr          (addr),
    .wdata         (wdata),
    .load_unsigned (load_unsigned),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_wstrb     (bus_wstrb),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic int nbytes_of(input mem_ctrl_t c);
    if (c == READ_HALF || c == STORE_HALF) return 2;
    if (c == READ_WORD || c == STORE_WORD) return 4;
    return 1;
  endfunction

  function automatic logic is_store(input mem_ctrl_t c);
    return c == STORE_BYTE || c == STORE_HALF || c == STORE_WORD;
  endfunction

  function automatic strb_t model_strb(input mem_ctrl_t c, input word_t a);
    strb_t m;
    if (!is_store(c)) return '0;
    m = 4'((1 << nbytes_of(c)) - 1);
    return m << (a % 4);
  endfunction

  function automatic word_t model_wdata(input mem_ctrl_t c, input word_t wd);
    word_t r;
    int n;
    n = nbytes_of(c);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic word_t model_load(input mem_ctrl_t c, input word_t a, input word_t rd, input logic uns);
    word_t v, mask;
    int bits;
    bits = 8 * nbytes_of(c);
    v = rd >> (8 * (a % 4));
    if (bits < 32) begin
      mask = (32'd1 << bits) - 32'd1;
      v = v & mask;
      if (!uns && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin
    checkOutput("busy", 32'(busy), 32'(txn_open));
    checkOutput("done", 32'(done), 32'(exp_done_now));
    checkOutput("req_valid", 32'(bus_req_valid), 32'(exp_req_valid));
    if (bus_req_valid && exp_req_valid) begin
      checkOutput("bus_addr", bus_addr, exp_bus_addr);
      checkOutput("bus_we", 32'(bus_we), 32'(exp_bus_we));
      checkOutput("bus_wstrb", 32'(bus_wstrb), 32'(exp_bus_wstrb));
      if (exp_bus_we) checkOutput("bus_wdata", bus_wdata, exp_bus_wdata);
    end
    if (exp_done_now) begin
      checkOutput("err", 32'(err), 32'(exp_err));
      model_rdata = exp_rdata_next;
    end
    checkOutput("rdata", rdata, model_rdata);
  end

  // One full transaction. rw = cycles ready stays low, rspw = WAIT_RSP cycles
  // before the response (negative: never). sid = pulse start in the done cycle.
  task automatic applyStimulus(input mem_ctrl_t c, input word_t a, input word_t wd, input logic uns,
                               input int rw, input int rspw, input word_t rsp_data, input logic sid);
    logic mis, tmo;
    int   edone;
    mis = (a % nbytes_of(c)) != 0;
    tmo = !mis && (rspw < 0 || rspw >= TIMEOUT);
    edone = mis ? 2 : (tmo ? 2 + rw + TIMEOUT : 3 + rw + rspw);
    cap_seen = 1'b0;
    done_at  = -1;
    @(posedge clk); #1;
    start = 1'b1; mem_ctrl = c; addr = a; wdata = wd; load_unsigned = uns;
    exp_bus_addr   = a & ~32'd3;
    exp_bus_we     = is_store(c);
    exp_bus_wstrb  = model_strb(c, a);
    exp_bus_wdata  = model_wdata(c, wd);
    exp_err        = mis || tmo;
    exp_rdata_next = (mis || tmo || is_store(c)) ? model_rdata : model_load(c, a, rsp_data, uns);
    for (int cyc = 1; cyc <= edone; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; mem_ctrl = NONE; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
      txn_open      = 1'b1;
      exp_req_valid = !mis && cyc <= 1 + rw;
      bus_req_ready = !mis && cyc == 1 + rw;
      bus_rsp_valid = (!mis && rspw >= 0 && cyc == 2 + rw + rspw) || (cyc < 1 + rw);
      bus_rdata     = (cyc == 2 + rw + rspw) ? rsp_data : 32'hDEAD_BEEF;
      exp_done_now  = cyc == edone;
      if (bus_req_valid && !cap_seen) begin
        cap_seen = 1'b1; cap_addr = bus_addr; cap_we = bus_we;
        cap_wstrb = bus_wstrb; cap_wdata = bus_wdata;
      end
      if (done && done_at < 0) done_at = cyc;
      if (cyc == edone && sid) begin
        start = 1'b1; mem_ctrl = READ_BYTE; addr = 32'h0;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; mem_ctrl = NONE;
    txn_open = 1'b0; exp_req_valid = 1'b0; exp_done_now = 1'b0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_req_valid", 32'(bus_req_valid), 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_bus_addr", bus_addr, 32'd0);
    rst = 1'b0;
    idleCycles(2);

    applyStimulus(STORE_BYTE, 32'h0000_1003, 32'h0000_00A5, 1'b0, 0, 0, 32'h0, 1'b0);
    checkOutput("sb_addr", cap_addr, 32'h0000_1000);
    checkOutput("sb_wstrb", 32'(cap_wstrb), 32'h8);
    checkOutput("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    checkOutput("sb_we", 32'(cap_we), 32'd1);
    checkOutput("sb_done_cycle", 32'(done_at), 32'd3);

    applyStimulus(READ_HALF, 32'h0000_2002, 32'h0, 1'b0, 0, 0, 32'h8001_1234, 1'b0);
    checkOutput("lh_signed", rdata, 32'hFFFF_8001);
    applyStimulus(READ_HALF, 32'h0000_2002, 32'h0, 1'b1, 0, 0, 32'h8001_1234, 1'b0);
    checkOutput("lh_unsigned", rdata, 32'h0000_8001);

    applyStimulus(READ_WORD, 32'h0000_3001, 32'h0, 1'b0, 0, 0, 32'h1111_1111, 1'b0);
    checkOutput("lw_mis_done_cycle", 32'(done_at), 32'd2);
    checkOutput("lw_mis_cap_seen", 32'(cap_seen), 32'd0);
    checkOutput("lw_mis_rdata_kept", rdata, 32'h0000_8001);

    applyStimulus(READ_BYTE, 32'h0000_4001, 32'h0, 1'b0, 3, 0, 32'h0000_7F00, 1'b0);
    checkOutput("lb_stall_rdata", rdata, 32'h0000_007F);
    checkOutput("lb_stall_done_cycle", 32'(done_at), 32'd6);

    applyStimulus(STORE_HALF, 32'h0000_6002, 32'h1234_BEEF, 1'b0, 1, 0, 32'h0, 1'b0);
    checkOutput("sh_wstrb", 32'(cap_wstrb), 32'hC);
    checkOutput("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    applyStimulus(READ_BYTE, 32'h0000_7003, 32'h0, 1'b0, 0, 1, 32'h80AA_BBCC, 1'b0);
    checkOutput("lb_signed_top", rdata, 32'hFFFF_FF80);
    applyStimulus(STORE_HALF, 32'h0000_8001, 32'h0000_1234, 1'b0, 0, 0, 32'h0, 1'b0);

    applyStimulus(READ_WORD, 32'h0000_9000, 32'h0, 1'b0, 0, -1, 32'h0, 1'b0);
    checkOutput("tmo_done_cycle", 32'(done_at), 32'd6);
    applyStimulus(READ_WORD, 32'h0000_9000, 32'h0, 1'b0, 0, 3, 32'hCAFE_F00D, 1'b0);
    checkOutput("tmo_edge_rdata", rdata, 32'hCAFE_F00D);
    checkOutput("tmo_edge_done_cycle", 32'(done_at), 32'd6);

    // Reset in the middle of WAIT_RSP.
    @(posedge clk); #1;
    start = 1'b1; mem_ctrl = READ_WORD; addr = 32'h0000_5000;
    exp_bus_addr = 32'h0000_5000; exp_bus_we = 1'b0; exp_bus_wstrb = '0;
    @(posedge clk); #1;
    start = 1'b0; mem_ctrl = NONE; txn_open = 1'b1; exp_req_valid = 1'b1; bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0; exp_req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; txn_open = 1'b0; model_rdata = '0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_bus_addr", bus_addr, 32'd0);
    checkOutput("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idleCycles(6);

    applyStimulus(STORE_WORD, 32'h0000_A000, 32'h0BAD_F00D, 1'b0, 0, 0, 32'h0, 1'b1);
    checkOutput("sw_wdata", cap_wdata, 32'h0BAD_F00D);
    idleCycles(4);

    @(posedge clk); #1;
    start = 1'b1; mem_ctrl = NONE; addr = 32'h0000_0004;
    @(posedge clk); #1;
    start = 1'b0;
    idleCycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
